// File: rtl/alu_seq_pkg.sv
// Shared opcodes, converter FSM states and active-low gfedcba 7-segment
// encodings used by the sequenced display ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ROL = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start loads a binary value, then one
// add-3/shift iteration per cycle for WIDTH cycles; done marks the last one.
module bin2bcd_seq #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

  // Shift datapath carries no reset; the control above gates its use.
  always_ff @(posedge clk) begin
    if (start_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
    end else if (busy_q) begin
      {bcd_q, bin_q} <= {adj, bin_q} << 1;
    end
  end

endmodule

// File: rtl/alu_seq_nb.sv
// N-bit 8-operation ALU with registered result/flags, auto-step or external
// opcode select, and a sequenced BCD converter driving three 7-segment groups.
module alu_seq_nb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 3,
  parameter int STEP_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [2:0]            op_ext,
  input  logic                  mode,
  output logic [2:0]            op_cur,
  output logic [WIDTH-1:0]      s,
  output logic                  cout,
  output logic                  zero,
  output logic                  busy,
  output logic                  valid,
  output logic [7*DIGITS-1:0]   seg_a,
  output logic [7*DIGITS-1:0]   seg_b,
  output logic [7*DIGITS-1:0]   seg_s
);

  localparam int PRE_W = $clog2(STEP_DIV);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam logic [SEG_W-1:0] SEG_ZEROS = {DIGITS{SEG_0}};

  logic [2:0]       op_q;
  logic [PRE_W-1:0] pre_q;
  logic             mode_q;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d, zero_q;
  logic [WIDTH:0]   sum;

  conv_state_e      state_q, state_d;
  logic             conv_start;
  logic             have_snap_q, valid_q;
  logic [WIDTH-1:0] snap_a_q, snap_b_q, snap_s_q;
  logic [BCD_W-1:0] bcd_a, bcd_b, bcd_s;
  logic             busy_ca, busy_cb, busy_cs;
  logic             done_ca, done_cb, done_cs;
  logic [SEG_W-1:0] seg_a_q, seg_b_q, seg_s_q;
  logic [SEG_W-1:0] pat_a, pat_b, pat_s;

  // Opcode select: prescaler restarts on any mode edge, op_cur is retained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      pre_q  <= '0;
      op_q   <= OP_ADD;
    end else begin
      mode_q <= mode;
      if (mode) op_q <= op_ext;
      if (mode != mode_q) begin
        pre_q <= '0;
      end else if (!mode) begin
        if (pre_q == PRE_W'(STEP_DIV - 1)) begin
          pre_q <= '0;
          op_q  <= op_q + 3'd1;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    s_d    = '0;
    cout_d = 1'b0;
    case (op_q)
      OP_ADD:  {cout_d, s_d} = sum;
      OP_SUB:  begin
        s_d    = a - b;
        cout_d = (a < b);
      end
      OP_ROL:  s_d = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  s_d = {a[0], a[WIDTH-1:1]};
      OP_OR:   s_d = a | b;
      OP_AND:  s_d = a & b;
      OP_XOR:  s_d = a ^ b;
      default: s_d = ~a;
    endcase
  end

  // ALU result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      zero_q <= (s_d == '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!have_snap_q || ({a, b, s_q} != {snap_a_q, snap_b_q, snap_s_q}))
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        conv_start = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (done_ca && done_cb && done_cs) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pat_a = '0;
    pat_b = '0;
    pat_s = '0;
    for (int d = 0; d < DIGITS; d++) begin
      pat_a[7*d +: 7] = bcd_to_seg(bcd_a[4*d +: 4]);
      pat_b[7*d +: 7] = bcd_to_seg(bcd_b[4*d +: 4]);
      pat_s[7*d +: 7] = bcd_to_seg(bcd_s[4*d +: 4]);
    end
  end

  // Display stage: segments and valid change together on leaving DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      have_snap_q <= 1'b0;
      valid_q     <= 1'b0;
      seg_a_q     <= SEG_ZEROS;
      seg_b_q     <= SEG_ZEROS;
      seg_s_q     <= SEG_ZEROS;
    end else begin
      state_q <= state_d;
      if (conv_start) have_snap_q <= 1'b1;
      if (state_q == ST_DONE) begin
        valid_q <= 1'b1;
        seg_a_q <= pat_a;
        seg_b_q <= pat_b;
        seg_s_q <= pat_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (conv_start) begin
      snap_a_q <= a;
      snap_b_q <= b;
      snap_s_q <= s_q;
    end
  end

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv_a (
    .clk(clk), .rst_n(rst_n), .start_i(conv_start), .bin_i(a),
    .busy_o(busy_ca), .done_o(done_ca), .bcd_o(bcd_a)
  );

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv_b (
    .clk(clk), .rst_n(rst_n), .start_i(conv_start), .bin_i(b),
    .busy_o(busy_cb), .done_o(done_cb), .bcd_o(bcd_b)
  );

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv_s (
    .clk(clk), .rst_n(rst_n), .start_i(conv_start), .bin_i(s_q),
    .busy_o(busy_cs), .done_o(done_cs), .bcd_o(bcd_s)
  );

  assign op_cur = op_q;
  assign s      = s_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign busy   = (state_q == ST_LOAD) || (state_q == ST_DONE) ||
                  busy_ca || busy_cb || busy_cs;
  assign valid  = valid_q;
  assign seg_a  = seg_a_q;
  assign seg_b  = seg_b_q;
  assign seg_s  = seg_s_q;

endmodule
